// File: rtl/pce_rom_loader.sv
// PCE ROM download write path: HPS words to DDR3/SDRAM stores via a
// toggle request/ack pair, plus image metadata for the core.
`timescale 1ns/1ps
module pce_rom_loader #(
  parameter int ADDR_W = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  input  logic              swap_bits,
  output logic [ADDR_W-1:0] romwr_a,
  output logic [15:0]       romwr_d,
  output logic              rom_wr,
  input  logic              dd_wrack,
  input  logic              sd_wrack,
  output logic [7:0]        rom_sz,
  output logic              hdr512,
  output logic [9:0]        rd_offset,
  output logic              populous,
  output logic              sgx,
  output logic              load_done
);

  typedef enum logic {
    S_IDLE,
    S_WAIT_ACK
  } state_t;

  state_t      state;
  logic        dl_q;
  logic        finish_pend;
  logic        defer;
  logic        rw_q;
  logic [1:0]  pop_flags;
  logic [15:0] word_q;

  logic        dl_start;
  logic        dl_end;
  logic        acks_eq;
  logic        accept;
  logic        sig_on;
  logic        sig_blk;
  logic        sig_bad;
  logic [15:0] sig_exp;
  logic [15:0] din_sw;
  logic        unused_idx;

  function automatic logic [15:0] bswap(
    input logic [15:0] w,
    input logic        en
  );
    logic [15:0] r;
    r = w;
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        r[i]     = w[7-i];
        r[8+i]   = w[15-i];
      end
    end
    return r;
  endfunction

  assign romwr_d    = bswap(word_q, swap_bits);
  assign din_sw     = bswap(ioctl_dout, swap_bits);
  assign rom_wr     = rw_q;
  assign rd_offset  = hdr512 ? 10'h200 : 10'h000;
  assign unused_idx = ^ioctl_index[7:5];

  assign dl_start = ioctl_download & ~dl_q;
  assign dl_end   = ~ioctl_download & dl_q;
  assign acks_eq  = (rw_q == dd_wrack) && (rw_q == sd_wrack);
  assign accept   = (state == S_IDLE) && ioctl_wr && !dl_start;

  // "POPULOUS" occupies bytes 6..13 of the 16-byte block
  always_comb begin
    sig_on  = 1'b0;
    sig_exp = 16'h0000;
    case (romwr_a[3:0])
      4'd6:    begin sig_on = 1'b1; sig_exp = 16'h4F50; end
      4'd8:    begin sig_on = 1'b1; sig_exp = 16'h5550; end
      4'd10:   begin sig_on = 1'b1; sig_exp = 16'h4F4C; end
      4'd12:   begin sig_on = 1'b1; sig_exp = 16'h5355; end
      default: begin sig_on = 1'b0; sig_exp = 16'h0000; end
    endcase
  end

  assign sig_blk = (romwr_a[23:4] == 20'h001F2) ||
                   (romwr_a[23:4] == 20'h00212);
  assign sig_bad = sig_on && sig_blk && (din_sw != sig_exp);

  // Request toggle survives reset so it stays paired with the controllers
  always_ff @(posedge clk_sys) begin
    if (!reset && acks_eq &&
        (accept || (state == S_WAIT_ACK && defer)))
      rw_q <= ~rw_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      ioctl_wait  <= 1'b0;
      romwr_a     <= '0;
      rom_sz      <= 8'h00;
      hdr512      <= 1'b0;
      populous    <= 1'b0;
      sgx         <= 1'b0;
      load_done   <= 1'b0;
      finish_pend <= 1'b0;
      pop_flags   <= 2'b11;
      dl_q        <= 1'b0;
      defer       <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      load_done <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            word_q     <= ioctl_dout;
            ioctl_wait <= 1'b1;
            defer      <= !acks_eq;
            state      <= S_WAIT_ACK;
            if (sig_bad)
              pop_flags[romwr_a[13]] <= 1'b0;
          end
        end
        S_WAIT_ACK: begin
          if (defer) begin
            if (acks_eq)
              defer <= 1'b0;
          end else if (acks_eq) begin
            ioctl_wait <= 1'b0;
            romwr_a    <= romwr_a + ADDR_W'(2);
            state      <= S_IDLE;
          end
        end
      endcase

      if (finish_pend && state == S_IDLE) begin
        hdr512      <= romwr_a[9];
        populous    <= pop_flags[romwr_a[9]];
        rom_sz      <= romwr_a[23:16];
        load_done   <= 1'b1;
        finish_pend <= 1'b0;
      end

      if (dl_end)
        finish_pend <= 1'b1;

      if (dl_start) begin
        romwr_a     <= '0;
        pop_flags   <= 2'b11;
        sgx         <= (ioctl_index[4:0] == 5'd2);
        hdr512      <= 1'b0;
        populous    <= 1'b0;
        finish_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pce_rom_loader.sv
// Bench for pce_rom_loader: random downloads against an image model
// with delayed-ack memory controller responders.
`timescale 1ns/1ps
module tb_pce_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        swap_bits;
  logic [23:0] romwr_a;
  logic [15:0] romwr_d;
  logic        rom_wr;
  logic        dd_wrack;
  logic        sd_wrack;
  logic [7:0]  rom_sz;
  logic        hdr512;
  logic [9:0]  rd_offset;
  logic        populous;
  logic        sgx;
  logic        load_done;

  pce_rom_loader #(.ADDR_W(24)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .swap_bits      (swap_bits),
    .romwr_a        (romwr_a),
    .romwr_d        (romwr_d),
    .rom_wr         (rom_wr),
    .dd_wrack       (dd_wrack),
    .sd_wrack       (sd_wrack),
    .rom_sz         (rom_sz),
    .hdr512         (hdr512),
    .rd_offset      (rd_offset),
    .populous       (populous),
    .sgx            (sgx),
    .load_done      (load_done)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory controller responders: ack follows rom_wr after N cycles
  int dd_lat = 1;
  int sd_lat = 1;
  int dd_cnt = 0;
  int sd_cnt = 0;

  initial begin
    dd_wrack = 1'b0;
    sd_wrack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (dd_wrack !== rom_wr) begin
        dd_cnt++;
        if (dd_cnt >= dd_lat) begin
          dd_wrack = rom_wr;
          dd_cnt   = 0;
        end
      end else dd_cnt = 0;
      if (sd_wrack !== rom_wr) begin
        sd_cnt++;
        if (sd_cnt >= sd_lat) begin
          sd_wrack = rom_wr;
          sd_cnt   = 0;
        end
      end else sd_cnt = 0;
    end
  end

  // Reference model: byte address -> word as the memories should see it
  logic [15:0] mimg [int];
  int          m_addr;
  bit          m_sgx;
  bit          m_swap;
  logic [7:0]  sig_b [8];

  function automatic logic [15:0] sw(input logic [15:0] w, input bit en);
    logic [7:0] hb, lb, rh, rl;
    hb = w[15:8];
    lb = w[7:0];
    if (!en) return w;
    rh = {<<{hb}};
    rl = {<<{lb}};
    return {rh, rl};
  endfunction

  function automatic bit model_pop(input int sz);
    int  base;
    int  a;
    bit  ok;
    logic [15:0] w;
    base = sz[9] ? 'h200 : 0;
    ok   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = base + 'h1F26 + 2 * k;
      w = {sig_b[2*k+1], sig_b[2*k]};
      if (mimg.exists(a) && mimg[a] != w) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int max_lat();
    return (dd_lat > sd_lat) ? dd_lat : sd_lat;
  endfunction

  task automatic begin_dl(input logic [7:0] idx, input bit swp);
    mimg.delete();
    m_addr         = 0;
    m_swap         = swp;
    m_sgx          = (idx[4:0] == 5'd2);
    ioctl_index    = idx;
    swap_bits      = swp;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("start_addr", romwr_a, 0);
    chk("start_sgx", sgx, m_sgx);
    chk("start_hdr", hdr512, 0);
    chk("start_pop", populous, 0);
    chk("start_wait", ioctl_wait, 0);
  endtask

  // mode 0: plain word, 1: inject a strobe during the ack wait,
  // 2: drop ioctl_download while the word is outstanding
  task automatic send_word(input logic [15:0] w, input int mode);
    logic prev;
    int   n;
    int   early;
    prev       = rom_wr;
    ioctl_dout = w;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    chk("wr_tgl", rom_wr, !prev);
    chk("wr_addr", romwr_a, m_addr);
    chk("wr_data", romwr_d, sw(w, m_swap));
    chk("wr_wait", ioctl_wait, 1);
    n     = 1;
    early = 0;
    while (ioctl_wait && n < 200) begin
      if (mode == 2 && n == 2) ioctl_download = 1'b0;
      if (mode == 1 && n == 5) begin
        ioctl_wr   = 1'b1;
        ioctl_dout = ~w;
      end
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if (load_done) early++;
      if (ioctl_wait) n++;
    end
    chk("wait_len", n, max_lat());
    mimg[m_addr] = sw(w, m_swap);
    m_addr = (m_addr + 2) & 'hFFFFFF;
    chk("adv_addr", romwr_a, m_addr);
    chk("one_tgl", rom_wr, !prev);
    if (mode == 1) chk("inj_data", romwr_d, sw(w, m_swap));
    if (mode == 2) chk("done_early", early, 0);
  endtask

  task automatic end_dl();
    int n;
    n = 0;
    if (ioctl_download) begin
      ioctl_download = 1'b0;
      do begin
        @(negedge clk_sys);
        n++;
      end while (!load_done && n < 40);
      chk("done_lat", n, 2);
    end else begin
      while (!load_done && n < 40) begin
        @(negedge clk_sys);
        n++;
      end
      chk("done_seen", load_done, 1);
    end
    chk("rom_sz", rom_sz, (m_addr >> 16) & 'hFF);
    chk("hdr512", hdr512, m_addr[9]);
    chk("rd_off", rd_offset, m_addr[9] ? 'h200 : 0);
    chk("populous", populous, model_pop(m_addr));
    chk("sgx", sgx, m_sgx);
    @(negedge clk_sys);
    chk("done_pulse", load_done, 0);
  endtask

  task automatic send_image(input bit corrupt);
    logic [7:0] b [2];
    int a;
    for (int base = 0; base < 'h2200; base += 2) begin
      for (int j = 0; j < 2; j++) begin
        a = base + j;
        if (a >= 'h2126 && a <= 'h212D) b[j] = sig_b[a - 'h2126];
        else b[j] = 8'($urandom);
        if (corrupt && a == 'h212A) b[j] = 8'h58;
      end
      send_word({b[1], b[0]}, 0);
    end
  endtask

  initial begin
    logic rw1;
    int   n;
    sig_b = '{8'h50, 8'h4F, 8'h50, 8'h55, 8'h4C, 8'h4F, 8'h55, 8'h53};
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 16'h0000;
    swap_bits      = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_addr", romwr_a, 0);
    chk("rst_sz", rom_sz, 0);
    chk("rst_hdr", hdr512, 0);
    chk("rst_pop", populous, 0);
    chk("rst_sgx", sgx, 0);
    chk("rst_done", load_done, 0);
    chk("rst_rw", rom_wr, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // four words, 4-cycle ack latency
    dd_lat = 4;
    sd_lat = 4;
    begin_dl(8'h01, 1'b0);
    send_word(16'h1234, 0);
    send_word(16'h5678, 0);
    send_word(16'h9ABC, 0);
    send_word(16'hDEF0, 0);
    end_dl();

    // bit swap and SuperGrafx index
    dd_lat = 1;
    sd_lat = 1;
    begin_dl(8'h02, 1'b1);
    send_word(16'h0180, 0);
    chk("swap_0180", romwr_d, 16'h8001);
    end_dl();

    // headered Populous image, then the corrupted variant
    begin_dl(8'h01, 1'b0);
    send_image(1'b0);
    end_dl();
    chk("pop_good", populous, 1);
    begin_dl(8'h01, 1'b0);
    send_image(1'b1);
    end_dl();
    chk("pop_bad", populous, 0);

    // slow DDR3 ack with a stray strobe during the wait
    begin_dl(8'h41, 1'b0);
    dd_lat = 20;
    sd_lat = 1;
    send_word(16'hA55A, 1);
    dd_lat = 1;
    end_dl();

    // window closes while the 256th word awaits its ack
    begin_dl(8'h00, 1'b0);
    for (int i = 0; i < 255; i++) send_word(16'($urandom), 0);
    dd_lat = 6;
    send_word(16'h1357, 2);
    dd_lat = 1;
    end_dl();

    // reset while a word is outstanding
    begin_dl(8'h22, 1'b0);
    dd_lat     = 8;
    ioctl_dout = 16'hBEEF;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    rw1 = rom_wr;
    chk("mid_wait", ioctl_wait, 1);
    reset          = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("mid_rst_wait", ioctl_wait, 0);
    chk("mid_rst_rw", rom_wr, rw1);
    chk("mid_rst_sgx", sgx, 0);
    n = 0;
    while ((dd_wrack !== rom_wr || sd_wrack !== rom_wr) && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    chk("mid_acks", (dd_wrack === rom_wr) && (sd_wrack === rom_wr), 1);
    dd_lat = 1;
    @(negedge clk_sys);

    // random downloads
    for (int r = 0; r < 8; r++) begin
      begin_dl(8'($urandom), 1'($urandom));
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        dd_lat = $urandom_range(1, 5);
        sd_lat = $urandom_range(1, 5);
        send_word(16'($urandom), 0);
      end
      end_dl();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
